// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared constants and entry type for the multi-lane
//               write-back stage. The localparams are the default values of
//               the wb_multi_stage and wb_lane_mux parameters.
// Contents    : WB_LANES, WB_DATA_W, WB_REG_AW, WB_HIST, WB_RD_PORTS,
//               wb_entry_t {valid, idx, data}
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int WB_LANES    = 2;
  localparam int WB_DATA_W   = 32;
  localparam int WB_REG_AW   = 5;
  localparam int WB_HIST     = 2;
  localparam int WB_RD_PORTS = 2;

  // One write-back record at the default widths. The top module declares a
  // copy of this layout that follows its own DATA_W/REG_AW parameters.
  typedef struct packed {
    logic                 valid;
    logic [WB_REG_AW-1:0] idx;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_lane_mux.sv
`default_nettype none
// ============================================================================
// Module      : wb_lane_mux
// Description : One write-back lane. Selects memory load data or the ALU
//               result, and drops any write aimed at register 0.
// Ports       : mem_sel   in  1       1 = memory data, 0 = ALU result
//               alu_data  in  DATA_W  ALU result
//               mem_data  in  DATA_W  memory load data
//               reg_idx   in  REG_AW  destination register
//               wb_req    in  1       write request
//               wr_data   out DATA_W  selected write data
//               wr_en     out 1       write request with register 0 removed
// Revision    : 1.0 - initial release
// ============================================================================
module wb_lane_mux
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_AW = WB_REG_AW
) (
  input  logic              mem_sel,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [REG_AW-1:0] reg_idx,
  input  logic              wb_req,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en
);

  assign wr_data = mem_sel ? mem_data : alu_data;
  assign wr_en   = wb_req && (reg_idx != '0);

endmodule
`default_nettype wire

// File: rtl/wb_multi_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_multi_stage
// Description : Multi-lane write-back stage with a pipe register and a
//               bypass history. Produces the register-file write port
//               combinationally, keeps HIST registered stages of recent
//               writes, and answers RD_PORTS forwarding lookups.
// Ports       : CLK, RESET (async, active-low), stall, flush
//               do_writeback/MemtoReg [LANES], writeRegister [LANES*REG_AW],
//               aluResult/Data_input [LANES*DATA_W]
//               writeData_OUT/aluResult_OUT/writeRegister_OUT/do_writeback_OUT
//                 - combinational write port
//               writeData_PR/writeRegister_PR/do_writeback_PR - stage 0
//               fwd_addr [RD_PORTS*REG_AW] -> fwd_hit [RD_PORTS],
//               fwd_data [RD_PORTS*DATA_W]
// Revision    : 1.0 - initial release
// ============================================================================
module wb_multi_stage
  import wb_pkg::*;
#(
  parameter int LANES    = WB_LANES,
  parameter int DATA_W   = WB_DATA_W,
  parameter int REG_AW   = WB_REG_AW,
  parameter int HIST     = WB_HIST,
  parameter int RD_PORTS = WB_RD_PORTS
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [LANES-1:0]           do_writeback,
  input  logic [LANES-1:0]           MemtoReg,
  input  logic [LANES*REG_AW-1:0]    writeRegister,
  input  logic [LANES*DATA_W-1:0]    aluResult,
  input  logic [LANES*DATA_W-1:0]    Data_input,
  output logic [LANES*DATA_W-1:0]    writeData_OUT,
  output logic [LANES*DATA_W-1:0]    aluResult_OUT,
  output logic [LANES*REG_AW-1:0]    writeRegister_OUT,
  output logic [LANES-1:0]           do_writeback_OUT,
  output logic [LANES*DATA_W-1:0]    writeData_PR,
  output logic [LANES*REG_AW-1:0]    writeRegister_PR,
  output logic [LANES-1:0]           do_writeback_PR,
  input  logic [RD_PORTS*REG_AW-1:0] fwd_addr,
  output logic [RD_PORTS-1:0]        fwd_hit,
  output logic [RD_PORTS*DATA_W-1:0] fwd_data
);

  // Same layout as wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] idx;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [LANES-1:0]  lane_en;
  logic [LANES-1:0]  lane_win;
  logic [REG_AW-1:0] lane_idx  [LANES];
  logic [REG_AW-1:0] port_addr [RD_PORTS];
  entry_t            cur       [LANES];
  entry_t            hist      [HIST][LANES];

  // --------------------------------------------------------------------------
  // Per-lane select and register-0 suppression
  // --------------------------------------------------------------------------
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = writeRegister[l*REG_AW +: REG_AW];

    wb_lane_mux #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
    ) u_lane_mux (
      .mem_sel  (MemtoReg[l]),
      .alu_data (aluResult[l*DATA_W +: DATA_W]),
      .mem_data (Data_input[l*DATA_W +: DATA_W]),
      .reg_idx  (lane_idx[l]),
      .wb_req   (do_writeback[l]),
      .wr_data  (writeData_OUT[l*DATA_W +: DATA_W]),
      .wr_en    (lane_en[l])
    );

    assign cur[l] = '{valid: lane_win[l],
                      idx:   lane_idx[l],
                      data:  writeData_OUT[l*DATA_W +: DATA_W]};

    assign writeData_PR[l*DATA_W +: DATA_W]     = hist[0][l].data;
    assign writeRegister_PR[l*REG_AW +: REG_AW] = hist[0][l].idx;
    assign do_writeback_PR[l]                   = hist[0][l].valid;
  end

  // A lane loses its write if any younger (higher-index) enabled lane targets
  // the same register in the same cycle.
  always_comb begin
    lane_win = lane_en;
    for (int l = 0; l < LANES; l++) begin
      for (int j = 0; j < LANES; j++) begin
        if (j > l && lane_en[j] && lane_idx[j] == lane_idx[l]) begin
          lane_win[l] = 1'b0;
        end
      end
    end
  end

  assign do_writeback_OUT  = RESET ? lane_win : '0;
  assign aluResult_OUT     = aluResult;
  assign writeRegister_OUT = writeRegister;

  // --------------------------------------------------------------------------
  // History: stage 0 is the pipe register, stage k follows stage k-1.
  // Flush only drops valid bits; the data/index stay visible on the PR ports.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int k = 0; k < HIST; k++) begin
        for (int l = 0; l < LANES; l++) begin
          hist[k][l] <= '0;
        end
      end
    end else if (flush) begin
      for (int k = 0; k < HIST; k++) begin
        for (int l = 0; l < LANES; l++) begin
          hist[k][l].valid <= 1'b0;
        end
      end
    end else if (!stall) begin
      for (int l = 0; l < LANES; l++) begin
        hist[0][l] <= cur[l];
        for (int k = 1; k < HIST; k++) begin
          hist[k][l] <= hist[k-1][l];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Forwarding. Candidates are scanned from lowest to highest priority so the
  // last match wins: oldest stage first, current lanes last, and within each
  // group the higher lane overrides the lower one.
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    assign port_addr[p] = fwd_addr[p*REG_AW +: REG_AW];
  end

  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (RESET && port_addr[p] != '0) begin
        for (int k = HIST-1; k >= 0; k--) begin
          for (int l = 0; l < LANES; l++) begin
            if (hist[k][l].valid && hist[k][l].idx == port_addr[p]) begin
              fwd_hit[p]                   = 1'b1;
              fwd_data[p*DATA_W +: DATA_W] = hist[k][l].data;
            end
          end
        end
        for (int l = 0; l < LANES; l++) begin
          if (cur[l].valid && cur[l].idx == port_addr[p]) begin
            fwd_hit[p]                   = 1'b1;
            fwd_data[p*DATA_W +: DATA_W] = cur[l].data;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_multi_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_multi_stage
// Description : Self-checking bench for wb_multi_stage at default parameters.
//               A driver applies one input set per cycle and pushes the
//               expected outputs from a behavioural model; a monitor pops
//               and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_multi_stage;

  localparam int L  = 2;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int H  = 2;
  localparam int RP = 2;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              stall, flush;
  logic [L-1:0]      do_writeback, MemtoReg;
  logic [L*AW-1:0]   writeRegister;
  logic [L*DW-1:0]   aluResult, Data_input;
  logic [L*DW-1:0]   writeData_OUT, aluResult_OUT;
  logic [L*AW-1:0]   writeRegister_OUT;
  logic [L-1:0]      do_writeback_OUT;
  logic [L*DW-1:0]   writeData_PR;
  logic [L*AW-1:0]   writeRegister_PR;
  logic [L-1:0]      do_writeback_PR;
  logic [RP*AW-1:0]  fwd_addr;
  logic [RP-1:0]     fwd_hit;
  logic [RP*DW-1:0]  fwd_data;

  wb_multi_stage #(
    .LANES(L), .DATA_W(DW), .REG_AW(AW), .HIST(H), .RD_PORTS(RP)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .stall             (stall),
    .flush             (flush),
    .do_writeback      (do_writeback),
    .MemtoReg          (MemtoReg),
    .writeRegister     (writeRegister),
    .aluResult         (aluResult),
    .Data_input        (Data_input),
    .writeData_OUT     (writeData_OUT),
    .aluResult_OUT     (aluResult_OUT),
    .writeRegister_OUT (writeRegister_OUT),
    .do_writeback_OUT  (do_writeback_OUT),
    .writeData_PR      (writeData_PR),
    .writeRegister_PR  (writeRegister_PR),
    .do_writeback_PR   (do_writeback_PR),
    .fwd_addr          (fwd_addr),
    .fwd_hit           (fwd_hit),
    .fwd_data          (fwd_data)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model: a list of write records per stage, newest stage first.
  // ------------------------------------------------------------------------
  typedef struct {
    bit          v;
    bit [AW-1:0] r;
    bit [DW-1:0] d;
  } ment_t;

  ment_t cur_m [L];
  ment_t st    [H][L];
  bit    m_stall, m_flush;

  typedef struct {
    logic [L*DW-1:0]  wd;
    logic [L-1:0]     dwb;
    logic [L*DW-1:0]  alu;
    logic [L*AW-1:0]  wr;
    logic [L*DW-1:0]  pr_d;
    logic [L*AW-1:0]  pr_r;
    logic [L-1:0]     pr_v;
    logic [RP-1:0]    hit;
    logic [RP*DW-1:0] fd;
  } exp_t;

  exp_t exp_q [$];

  function automatic void lookup(input bit [AW-1:0] a, output bit h, output bit [DW-1:0] d);
    h = 0;
    d = '0;
    if (a == 0) return;
    for (int l = L-1; l >= 0; l--)
      if (cur_m[l].v && cur_m[l].r == a) begin h = 1; d = cur_m[l].d; return; end
    for (int k = 0; k < H; k++)
      for (int l = L-1; l >= 0; l--)
        if (st[k][l].v && st[k][l].r == a) begin h = 1; d = st[k][l].d; return; end
  endfunction

  // Clock edge as seen by the model.
  task automatic model_edge();
    if (m_flush) begin
      for (int k = 0; k < H; k++)
        for (int l = 0; l < L; l++) st[k][l].v = 0;
    end else if (!m_stall) begin
      for (int k = H-1; k > 0; k--) st[k] = st[k-1];
      for (int l = 0; l < L; l++) st[0][l] = cur_m[l];
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < H; k++)
      for (int l = 0; l < L; l++) st[k][l] = '{v: 0, r: '0, d: '0};
  endtask

  task automatic apply(input bit s, input bit f, input bit [L-1:0] wb, input bit [L-1:0] m2r,
                       input bit [L*AW-1:0] regs, input bit [L*DW-1:0] alu,
                       input bit [L*DW-1:0] mem, input bit [RP*AW-1:0] fa);
    stall = s; flush = f; do_writeback = wb; MemtoReg = m2r;
    writeRegister = regs; aluResult = alu; Data_input = mem; fwd_addr = fa;
    m_stall = s; m_flush = f;
    for (int l = 0; l < L; l++) begin
      bit [AW-1:0] r;
      bit          younger;
      r = regs[l*AW +: AW];
      younger = 0;
      for (int j = l + 1; j < L; j++)
        if (wb[j] && regs[j*AW +: AW] == r) younger = 1;
      cur_m[l].r = r;
      cur_m[l].d = m2r[l] ? mem[l*DW +: DW] : alu[l*DW +: DW];
      cur_m[l].v = wb[l] && (r != 0) && !younger;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.alu = aluResult;
    e.wr  = writeRegister;
    for (int l = 0; l < L; l++) begin
      e.wd[l*DW +: DW]   = cur_m[l].d;
      e.dwb[l]           = cur_m[l].v;
      e.pr_d[l*DW +: DW] = st[0][l].d;
      e.pr_r[l*AW +: AW] = st[0][l].r;
      e.pr_v[l]          = st[0][l].v;
    end
    for (int p = 0; p < RP; p++) begin
      bit          h;
      bit [DW-1:0] d;
      lookup(fwd_addr[p*AW +: AW], h, d);
      e.hit[p]         = h;
      e.fd[p*DW +: DW] = d;
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit s, input bit f, input bit [L-1:0] wb, input bit [L-1:0] m2r,
                       input bit [L*AW-1:0] regs, input bit [L*DW-1:0] alu,
                       input bit [L*DW-1:0] mem, input bit [RP*AW-1:0] fa);
    @(posedge CLK);
    model_edge();
    #1;
    apply(s, f, wb, m2r, regs, alu, mem, fa);
    push_expected();
  endtask

  // ------------------------------------------------------------------------
  // Monitor
  // ------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("writeData_OUT",     64'(writeData_OUT),     64'(e.wd));
        chk("do_writeback_OUT",  64'(do_writeback_OUT),  64'(e.dwb));
        chk("aluResult_OUT",     64'(aluResult_OUT),     64'(e.alu));
        chk("writeRegister_OUT", 64'(writeRegister_OUT), 64'(e.wr));
        chk("writeData_PR",      64'(writeData_PR),      64'(e.pr_d));
        chk("writeRegister_PR",  64'(writeRegister_PR),  64'(e.pr_r));
        chk("do_writeback_PR",   64'(do_writeback_PR),   64'(e.pr_v));
        chk("fwd_hit",           64'(fwd_hit),           64'(e.hit));
        chk("fwd_data",          64'(fwd_data),          64'(e.fd));
      end
    end
  end

  // Asynchronous reset pulse between edges; the PR ports must clear at once.
  task automatic reset_pulse();
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    chk("rst_async do_writeback_PR",  64'(do_writeback_PR),  64'd0);
    chk("rst_async writeData_PR",     64'(writeData_PR),     64'd0);
    chk("rst_async writeRegister_PR", 64'(writeRegister_PR), 64'd0);
    chk("rst_async fwd_hit",          64'(fwd_hit),          64'd0);
    apply(0, 0, 2'b01, 2'b00, {5'd0, 5'd12}, {32'd0, 32'h55}, '0, {5'd12, 5'd12});
    #1;
    chk("rst do_writeback_OUT forced", 64'(do_writeback_OUT), 64'd0);
    chk("rst fwd_hit forced",          64'(fwd_hit),          64'd0);
    model_clear();
    @(posedge CLK);
    #1;
    chk("rst held over edge do_writeback_PR", 64'(do_writeback_PR), 64'd0);
    #2;
    RESET = 1'b1;
  endtask

  // ------------------------------------------------------------------------
  // Driver
  // ------------------------------------------------------------------------
  initial begin
    RESET = 1'b0;
    model_clear();
    apply(0, 0, '0, '0, '0, '0, '0, '0);
    #12;
    chk("reset do_writeback_PR",  64'(do_writeback_PR),  64'd0);
    chk("reset writeData_PR",     64'(writeData_PR),     64'd0);
    chk("reset writeRegister_PR", 64'(writeRegister_PR), 64'd0);
    chk("reset fwd_hit",          64'(fwd_hit),          64'd0);
    #9;
    RESET = 1'b1;

    // Memory select on lane 0, then observe it in the pipe register.
    cycle(0, 0, 2'b01, 2'b01, {5'd0, 5'd3}, {32'd0, 32'h1}, {32'd0, 32'hDEADBEEF}, {5'd0, 5'd3});
    cycle(0, 0, 2'b00, 2'b00, '0, '0, '0, {5'd3, 5'd0});
    // Two lanes to the same register: the younger lane wins.
    cycle(0, 0, 2'b11, 2'b00, {5'd7, 5'd7}, {32'h22, 32'h11}, '0, {5'd7, 5'd7});
    // Register 0 is never written or forwarded.
    cycle(0, 0, 2'b01, 2'b00, {5'd0, 5'd0}, {32'd0, 32'hFFFF}, '0, {5'd0, 5'd0});
    // History depth: reg 5 visible for HIST cycles after the write, then gone.
    cycle(0, 0, 2'b01, 2'b00, {5'd0, 5'd5}, {32'd0, 32'hA}, '0, {5'd5, 5'd5});
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, '0, '0, '0, '0, {5'd5, 5'd5});
    // Flush beats stall.
    cycle(0, 0, 2'b10, 2'b00, {5'd9, 5'd0}, {32'h99, 32'd0}, '0, {5'd9, 5'd9});
    cycle(1, 1, '0, '0, '0, '0, '0, {5'd9, 5'd9});
    cycle(0, 0, '0, '0, '0, '0, '0, {5'd9, 5'd9});
    // Stall holds the history.
    cycle(0, 0, 2'b01, 2'b00, {5'd0, 5'd14}, {32'd0, 32'h1414}, '0, {5'd14, 5'd0});
    for (int i = 0; i < 3; i++) cycle(1, 0, '0, '0, '0, '0, '0, {5'd14, 5'd14});
    cycle(0, 0, '0, '0, '0, '0, '0, {5'd14, 5'd14});

    // Randomized traffic over a small register range to force collisions.
    for (int i = 0; i < 300; i++) begin
      bit [L*AW-1:0] regs;
      bit [RP*AW-1:0] fa;
      for (int l = 0; l < L; l++) regs[l*AW +: AW] = AW'($urandom_range(0, 7));
      for (int p = 0; p < RP; p++) fa[p*AW +: AW] = AW'($urandom_range(0, 7));
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
            L'($urandom), L'($urandom), regs,
            {$urandom, $urandom}, {$urandom, $urandom}, fa);
      if (i == 150) begin
        cycle(0, 0, 2'b01, 2'b00, {5'd0, 5'd20}, {32'd0, 32'h2020}, '0, {5'd20, 5'd20});
        cycle(0, 0, '0, '0, '0, '0, '0, {5'd20, 5'd20});
        reset_pulse();
      end
    end

    repeat (3) @(negedge CLK);
    #1;
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
